memory_access_arbiter: RTL and testbench
========================================

MEMORY_ACCESS_ARBITER -- requirements
Module: memory_access_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 1, meaning memory access cycles per transaction (legal range 1..15).
REQ-002 SHALL have port MAA_clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port MAA_rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port MAA_f_req  input  1  fetch requester read request.
REQ-005 SHALL have port MAA_f_addr  input  8  fetch address.
REQ-006 SHALL have port MAA_f_done  output  1  one-cycle completion pulse to fetch requester.
REQ-007 SHALL have port MAA_d_req  input  1  data requester request.
REQ-008 SHALL have port MAA_d_we  input  1  data requester write (1) or read (0).
REQ-009 SHALL have port MAA_d_addr  input  8  data address.
REQ-010 SHALL have port MAA_d_wdata  input  16  data write value.
REQ-011 SHALL have port MAA_d_done  output  1  one-cycle completion pulse to data requester.
REQ-012 SHALL have port MAA_rdata  output  16  read result, valid with either done pulse and held until the next done.
REQ-013 SHALL have port MAA_mar_addr  output  8  address driven to the memory address register input.
REQ-014 SHALL have port MAA_mar_wr_en  output  1  memory address register write enable.
REQ-015 SHALL have port MAA_mem_rd_en / MAA_mem_wr_en  output  1 each  memory read/write strobes.
REQ-016 SHALL have port MAA_mem_wdata  output  16  memory write data; MAA_mem_rdata  input  16  memory read data.
REQ-017 SHALL have port MAA_busy  output  1  high in every state except IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, LOAD, ACCESS, DONE.
REQ-019 IDLE: if any req high at the rising edge, SHALL latch the winner's id, addr, we and wdata (fetch: we=0) and go to LOAD; otherwise stay IDLE.
REQ-020 Arbitration SHALL be round-robin: when both requests are high, the requester not granted last wins; the last-grant pointer updates on each grant.
REQ-021 LOAD (1 cycle): MAA_mar_wr_en=1 and MAA_mar_addr=latched addr; next state ACCESS.
REQ-022 ACCESS SHALL last exactly MEM_LAT cycles, with MAA_mem_rd_en (we=0) or MAA_mem_wr_en (we=1) high in each cycle and MAA_mem_wdata=latched wdata; a 4-bit down-counter SHALL time it.
REQ-023 For reads, MAA_rdata SHALL capture MAA_mem_rdata at the edge ending the last ACCESS cycle; writes SHALL leave MAA_rdata unchanged.
REQ-024 DONE (1 cycle): exactly one of MAA_f_done/MAA_d_done, selected by the latched id, SHALL be high; next state IDLE.
REQ-025 Latency: with the request accepted at edge N, done SHALL be high in cycle N+2+MEM_LAT; back-to-back throughput SHALL be one transaction per 3+MEM_LAT cycles.
REQ-026 Requests SHALL be sampled only in IDLE; a req drop or change of addr/wdata after acceptance SHALL NOT affect the transaction in flight.
REQ-027 A requester SHALL drop req in the cycle after its done; a req still high in IDLE SHALL count as a new request.
REQ-028 MAA_mar_wr_en, MAA_mem_rd_en, MAA_mem_wr_en and the done outputs SHALL be 0 in every state and cycle not named above; the two memory strobes SHALL never be high together.

Reset
REQ-029 MAA_rst_n low SHALL immediately force state IDLE, the counter to 0, the last-grant pointer to "data", MAA_rdata, MAA_mar_addr and MAA_mem_wdata to 0, and all strobes, done and busy outputs to 0.
REQ-030 Reset asserted mid-transaction SHALL abort it with no done pulse; the first grant after reset SHALL go to fetch if both requesters request.

Structure
REQ-031 The state encodings (2-bit) and requester id constants SHALL live in the shared package memory_ctrl_pkg.
REQ-032 The two-way round-robin decision SHALL be a sub-module rr_arbiter_2 (inputs: two requests, pointer; output: one-hot grant).

Verification
REQ-033 Fetch read, MEM_LAT=1, addr 8'h2A, memory returns 16'hBEEF -> mar_wr_en high 1 cycle with 8'h2A, mem_rd_en high 1 cycle, f_done at N+3, rdata=16'hBEEF.
REQ-034 Data write, addr 8'h10, wdata 16'h1234 -> mem_wr_en high with mem_wdata=16'h1234, d_done pulses, rdata unchanged.
REQ-035 f_req and d_req high together, held across 3 transactions -> grant order fetch, data, fetch.
REQ-036 MEM_LAT=3 read -> mem_rd_en high 3 consecutive cycles, done at N+5.
REQ-037 Reset pulsed during ACCESS -> all outputs 0 at once, no done; the next request completes normally.
REQ-038 d_addr changed from 8'h10 to 8'h55 the cycle after acceptance -> MAA_mar_addr=8'h10.

Source files
------------

// File: rtl/memory_ctrl_pkg.sv
// Shared encodings for the memory access arbiter: FSM states and requester ids.
package memory_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic ID_FETCH = 1'b0;
  localparam logic ID_DATA  = 1'b1;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin decision: on contention the requester not granted last wins.
module rr_arbiter_2
  import memory_ctrl_pkg::*;
(
  input  logic       req_f,
  input  logic       req_d,
  input  logic       last_id,
  output logic [1:0] gnt
);

  // gnt[0] = fetch, gnt[1] = data
  always_comb begin
    gnt = 2'b00;
    if (req_f && req_d) begin
      if (last_id == ID_DATA) begin
        gnt = 2'b01;
      end else begin
        gnt = 2'b10;
      end
    end else if (req_f) begin
      gnt = 2'b01;
    end else if (req_d) begin
      gnt = 2'b10;
    end else begin
      gnt = 2'b00;
    end
  end

endmodule

// File: rtl/memory_access_arbiter.sv
// Arbitrates a fetch and a data requester onto one memory port through a
// LOAD / ACCESS / DONE sequence; all outputs come straight from flops.
module memory_access_arbiter
  import memory_ctrl_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1
)
(
  input  logic        MAA_clk,
  input  logic        MAA_rst_n,
  input  logic        MAA_f_req,
  input  logic [7:0]  MAA_f_addr,
  output logic        MAA_f_done,
  input  logic        MAA_d_req,
  input  logic        MAA_d_we,
  input  logic [7:0]  MAA_d_addr,
  input  logic [15:0] MAA_d_wdata,
  output logic        MAA_d_done,
  output logic [15:0] MAA_rdata,
  output logic [7:0]  MAA_mar_addr,
  output logic        MAA_mar_wr_en,
  output logic        MAA_mem_rd_en,
  output logic        MAA_mem_wr_en,
  output logic [15:0] MAA_mem_wdata,
  input  logic [15:0] MAA_mem_rdata,
  output logic        MAA_busy
);

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        id_q, id_d;
  logic        we_q, we_d;
  logic        ptr_q, ptr_d;
  logic [7:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        mar_wr_en_q, mar_wr_en_d;
  logic        mem_rd_en_q, mem_rd_en_d;
  logic        mem_wr_en_q, mem_wr_en_d;
  logic        f_done_q, f_done_d;
  logic        d_done_q, d_done_d;
  logic        busy_q, busy_d;
  logic [1:0]  gnt_s;

  rr_arbiter_2 u_rr (
    .req_f   (MAA_f_req),
    .req_d   (MAA_d_req),
    .last_id (ptr_q),
    .gnt     (gnt_s)
  );

  // Next-state, transaction latch and output decode from the next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    we_d    = we_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_s != 2'b00) begin
          id_d    = gnt_s[1];
          ptr_d   = gnt_s[1];
          addr_d  = gnt_s[1] ? MAA_d_addr : MAA_f_addr;
          we_d    = gnt_s[1] & MAA_d_we;
          wdata_d = gnt_s[1] ? MAA_d_wdata : 16'h0000;
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        cnt_d   = LAT_M1;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_DONE;
          rdata_d = we_q ? rdata_q : MAA_mem_rdata;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    mar_wr_en_d = (state_d == ST_LOAD);
    mem_rd_en_d = (state_d == ST_ACCESS) && !we_d;
    mem_wr_en_d = (state_d == ST_ACCESS) && we_d;
    f_done_d    = (state_d == ST_DONE) && (id_d == ID_FETCH);
    d_done_d    = (state_d == ST_DONE) && (id_d == ID_DATA);
    busy_d      = (state_d != ST_IDLE);
  end

  // State, latched transaction and registered outputs
  always_ff @(posedge MAA_clk or negedge MAA_rst_n) begin
    if (!MAA_rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      id_q        <= ID_FETCH;
      we_q        <= 1'b0;
      ptr_q       <= ID_DATA;
      addr_q      <= 8'h00;
      wdata_q     <= 16'h0000;
      rdata_q     <= 16'h0000;
      mar_wr_en_q <= 1'b0;
      mem_rd_en_q <= 1'b0;
      mem_wr_en_q <= 1'b0;
      f_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      id_q        <= id_d;
      we_q        <= we_d;
      ptr_q       <= ptr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      mar_wr_en_q <= mar_wr_en_d;
      mem_rd_en_q <= mem_rd_en_d;
      mem_wr_en_q <= mem_wr_en_d;
      f_done_q    <= f_done_d;
      d_done_q    <= d_done_d;
      busy_q      <= busy_d;
    end
  end

  assign MAA_f_done    = f_done_q;
  assign MAA_d_done    = d_done_q;
  assign MAA_rdata     = rdata_q;
  assign MAA_mar_addr  = addr_q;
  assign MAA_mar_wr_en = mar_wr_en_q;
  assign MAA_mem_rd_en = mem_rd_en_q;
  assign MAA_mem_wr_en = mem_wr_en_q;
  assign MAA_mem_wdata = wdata_q;
  assign MAA_busy      = busy_q;

endmodule

// File: tb/tb_memory_access_arbiter.sv
// Scoreboard bench: stimulus pushes expected transactions, monitors pop on done.
module tb_memory_access_arbiter;

  typedef struct {
    logic        is_d;
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // MEM_LAT = 1 instance
  logic        rst_n, f_req, f_done, d_req, d_we, d_done;
  logic        mar_wr_en, mem_rd_en, mem_wr_en, busy;
  logic [7:0]  f_addr, d_addr, mar_addr;
  logic [15:0] d_wdata, rdata, mem_wdata, mem_rdata;
  logic [15:0] mem [256];
  logic [7:0]  mar_r;

  // MEM_LAT = 3 instance
  logic        rst_n3, f_req3, f_done3, d_req3, d_we3, d_done3;
  logic        mar_wr_en3, mem_rd_en3, mem_wr_en3, busy3;
  logic [7:0]  f_addr3, d_addr3, mar_addr3;
  logic [15:0] d_wdata3, rdata3, mem_wdata3, mem_rdata3;

  exp_t        sb[$];
  logic [15:0] sb3[$];
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int          done_cnt3 = 0;

  memory_access_arbiter #(.MEM_LAT(1)) dut (
    .MAA_clk(clk), .MAA_rst_n(rst_n),
    .MAA_f_req(f_req), .MAA_f_addr(f_addr), .MAA_f_done(f_done),
    .MAA_d_req(d_req), .MAA_d_we(d_we), .MAA_d_addr(d_addr),
    .MAA_d_wdata(d_wdata), .MAA_d_done(d_done), .MAA_rdata(rdata),
    .MAA_mar_addr(mar_addr), .MAA_mar_wr_en(mar_wr_en),
    .MAA_mem_rd_en(mem_rd_en), .MAA_mem_wr_en(mem_wr_en),
    .MAA_mem_wdata(mem_wdata), .MAA_mem_rdata(mem_rdata), .MAA_busy(busy)
  );

  memory_access_arbiter #(.MEM_LAT(3)) dut3 (
    .MAA_clk(clk), .MAA_rst_n(rst_n3),
    .MAA_f_req(f_req3), .MAA_f_addr(f_addr3), .MAA_f_done(f_done3),
    .MAA_d_req(d_req3), .MAA_d_we(d_we3), .MAA_d_addr(d_addr3),
    .MAA_d_wdata(d_wdata3), .MAA_d_done(d_done3), .MAA_rdata(rdata3),
    .MAA_mar_addr(mar_addr3), .MAA_mar_wr_en(mar_wr_en3),
    .MAA_mem_rd_en(mem_rd_en3), .MAA_mem_wr_en(mem_wr_en3),
    .MAA_mem_wdata(mem_wdata3), .MAA_mem_rdata(mem_rdata3), .MAA_busy(busy3)
  );

  assign mem_rdata  = mem[mar_r];
  assign mem_rdata3 = 16'hCAFE;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_event(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  // Memory model behind the address register
  initial begin
    mar_r = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h2A] = 16'hBEEF;
    forever begin
      @(posedge clk);
      if (mar_wr_en) mar_r <= mar_addr;
      if (mem_wr_en) mem[mar_r] <= mem_wdata;
    end
  end

  // Monitor for the MEM_LAT = 1 instance
  initial begin
    time  load_t;
    int   rd_c;
    int   wr_c;
    exp_t e;
    load_t = 0;
    rd_c = 0;
    wr_c = 0;
    forever begin
      @(negedge clk);
      chk("strobe_excl", 32'(mem_rd_en & mem_wr_en), 32'd0);
      if (mar_wr_en) begin
        rd_c = 0;
        wr_c = 0;
        load_t = $time;
        if (sb.size() == 0) fail_event("unexpected_load");
        else chk("mar_addr", 32'(mar_addr), 32'(sb[0].addr));
      end
      if (mem_rd_en) rd_c++;
      if (mem_wr_en) begin
        wr_c++;
        if (sb.size() != 0) chk("mem_wdata", 32'(mem_wdata), 32'(sb[0].wdata));
      end
      if (f_done | d_done) begin
        done_cnt++;
        if (sb.size() == 0) fail_event("unexpected_done");
        else begin
          e = sb.pop_front();
          chk("done_id", 32'({d_done, f_done}), e.is_d ? 32'd2 : 32'd1);
          chk("rdata", 32'(rdata), 32'(e.rdata));
          chk("strobe_cnt", 32'(e.we ? wr_c : rd_c), 32'd1);
          chk("other_strobe", 32'(e.we ? rd_c : wr_c), 32'd0);
          chk("latency", 32'(($time - load_t) / 10), 32'd2);
          chk("busy_done", 32'(busy), 32'd1);
        end
      end
    end
  end

  // Monitor for the MEM_LAT = 3 instance
  initial begin
    time load_t;
    int  rd_c;
    load_t = 0;
    rd_c = 0;
    forever begin
      @(negedge clk);
      if (mar_wr_en3) begin
        rd_c = 0;
        load_t = $time;
      end
      if (mem_rd_en3) rd_c++;
      if (f_done3 | d_done3) begin
        done_cnt3++;
        if (sb3.size() == 0) fail_event("unexpected_done3");
        else begin
          chk("done_id3", 32'({d_done3, f_done3}), 32'd1);
          chk("rdata3", 32'(rdata3), 32'(sb3.pop_front()));
          chk("rd_cnt3", 32'(rd_c), 32'd3);
          chk("latency3", 32'(($time - load_t) / 10), 32'd4);
        end
      end
    end
  end

  task automatic wait_dones(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("done_timeout", 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_mar_we"}, 32'(mar_wr_en), 32'd0);
    chk({tag, "_rd_en"}, 32'(mem_rd_en), 32'd0);
    chk({tag, "_wr_en"}, 32'(mem_wr_en), 32'd0);
    chk({tag, "_dones"}, 32'({f_done, d_done}), 32'd0);
    chk({tag, "_rdata"}, 32'(rdata), 32'd0);
    chk({tag, "_mar"},   32'(mar_addr), 32'd0);
    chk({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
  endtask

  // Single transaction; inputs are scrambled right after acceptance
  task automatic issue(input logic is_d, input logic we, input logic [7:0] addr,
                       input logic [15:0] wdata, input logic [15:0] exp_rd);
    int tgt;
    tgt = done_cnt + 1;
    sb.push_back('{is_d, we, addr, wdata, exp_rd});
    @(negedge clk);
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      f_req = 1'b1; f_addr = addr;
    end
    @(posedge clk);
    #1;
    f_req = 1'b0; d_req = 1'b0;
    f_addr = 8'h55; d_addr = 8'h55; d_wdata = 16'hFFFF;
    wait_dones(tgt);
  endtask

  // Both requesters held high (data side reads) for n transactions
  task automatic hold_both(input int n);
    int tgt;
    tgt = done_cnt + n;
    @(negedge clk);
    f_req = 1'b1; f_addr = 8'h2A;
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h10;
    wait_dones(tgt);
    f_req = 1'b0; d_req = 1'b0;
  endtask

  initial begin
    int saved;
    int n;
    rst_n = 1'b0; f_req = 1'b0; f_addr = 8'h00;
    d_req = 1'b0; d_we = 1'b0; d_addr = 8'h00; d_wdata = 16'h0000;
    rst_n3 = 1'b0; f_req3 = 1'b0; f_addr3 = 8'h00;
    d_req3 = 1'b0; d_we3 = 1'b0; d_addr3 = 8'h00; d_wdata3 = 16'h0000;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    rst_n3 = 1'b1;

    issue(1'b0, 1'b0, 8'h2A, 16'h0000, 16'hBEEF);
    issue(1'b1, 1'b1, 8'h10, 16'h1234, 16'hBEEF);
    sb.push_back('{1'b0, 1'b0, 8'h2A, 16'h0000, 16'hBEEF});
    sb.push_back('{1'b1, 1'b0, 8'h10, 16'h0000, 16'h1234});
    sb.push_back('{1'b0, 1'b0, 8'h2A, 16'h0000, 16'hBEEF});
    hold_both(3);

    // Abort a fetch during ACCESS with a reset pulse
    saved = done_cnt;
    sb.push_back('{1'b0, 1'b0, 8'h2A, 16'h0000, 16'hBEEF});
    @(negedge clk);
    f_req = 1'b1; f_addr = 8'h2A;
    @(posedge clk);
    #1;
    f_req = 1'b0;
    n = 0;
    while (!mem_rd_en && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("access_seen", 32'(mem_rd_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check_zero("abort");
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt), 32'(saved));

    sb.push_back('{1'b0, 1'b0, 8'h2A, 16'h0000, 16'hBEEF});
    sb.push_back('{1'b1, 1'b0, 8'h10, 16'h0000, 16'h1234});
    hold_both(2);

    // MEM_LAT = 3 read
    sb3.push_back(16'hCAFE);
    @(negedge clk);
    f_req3 = 1'b1; f_addr3 = 8'h33;
    @(posedge clk);
    #1;
    f_req3 = 1'b0;
    n = 0;
    while (done_cnt3 < 1 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("done3_timeout", 32'(done_cnt3), 32'd1);

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
